wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter_pkg.sv | 21 ++
 rtl/wb_port_arbiter_rr_multi_pick.sv | 47 ++++
 rtl/wb_port_arbiter.sv | 86 ++++++++
 3 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared core types for the writeback port arbiter: scoreboard tag width, data width,
// exception record and the bundled writeback port.
package wb_port_arbiter_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic                     valid;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          data;
    exception_t               ex;
  } wb_port_t;

endpackage

// File: rtl/wb_port_arbiter_rr_multi_pick.sv
// Combinational round-robin picker: grants up to NR_WB_PORTS valid requesters scanned from
// i_ptr, the n-th grant in scan order lands on port n, and returns the pointer past the last grant.
module rr_multi_pick #(
  parameter int unsigned NR_REQ      = 4,
  parameter int unsigned NR_WB_PORTS = 2,
  parameter int unsigned PTR_W       = 2
) (
  input  logic [NR_REQ-1:0]                  i_valid,
  input  logic [PTR_W-1:0]                   i_ptr,
  output logic [NR_WB_PORTS-1:0][NR_REQ-1:0] o_grant,
  output logic [NR_REQ-1:0]                  o_ready,
  output logic [PTR_W-1:0]                   o_ptr_next
);

  localparam int unsigned CNT_W = $clog2(NR_WB_PORTS + 1);

  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    o_grant    = '0;
    o_ready    = '0;
    o_ptr_next = i_ptr;
    sum        = '0;
    idx        = '0;
    cnt        = '0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      // Scan position i maps to requester (ptr + i) mod NR_REQ.
      sum = {1'b0, i_ptr} + (PTR_W + 1)'(i);
      if (sum >= (PTR_W + 1)'(NR_REQ)) begin
        sum = sum - (PTR_W + 1)'(NR_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (i_valid[idx] && (cnt < CNT_W'(NR_WB_PORTS))) begin
        for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
          if (cnt == CNT_W'(p)) begin
            o_grant[p][idx] = 1'b1;
          end
        end
        o_ready[idx] = 1'b1;
        cnt          = cnt + CNT_W'(1);
        o_ptr_next   = (idx == PTR_W'(NR_REQ - 1)) ? '0 : idx + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: round-robin selects up to NR_WB_PORTS functional-unit results per
// cycle and registers them onto the scoreboard writeback ports.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned NR_REQ      = 4,
  parameter int unsigned NR_WB_PORTS = 2
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         flush_i,
  input  logic [NR_REQ-1:0]                            req_valid_i,
  output logic [NR_REQ-1:0]                            req_ready_o,
  input  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]         req_trans_id_i,
  input  logic [NR_REQ-1:0][XLEN-1:0]                  req_data_i,
  input  exception_t [NR_REQ-1:0]                      req_ex_i,
  output logic [NR_WB_PORTS-1:0]                       wt_valid_o,
  output logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]    trans_id_o,
  output logic [NR_WB_PORTS-1:0][XLEN-1:0]             wbdata_o,
  output exception_t [NR_WB_PORTS-1:0]                 ex_o
);

  localparam int unsigned PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  if ((NR_WB_PORTS < 1) || (NR_REQ < NR_WB_PORTS)) begin : g_param_check
    $error("wb_port_arbiter: requires NR_REQ >= NR_WB_PORTS >= 1");
  end

  logic [NR_REQ-1:0]                  w_req_valid;
  logic [NR_WB_PORTS-1:0][NR_REQ-1:0] w_grant;
  logic [NR_REQ-1:0]                  w_ready;
  logic [PTR_W-1:0]                   w_ptr_next;
  wb_port_t [NR_WB_PORTS-1:0]         w_port_d;

  logic [PTR_W-1:0]                   r_rr_ptr;
  wb_port_t [NR_WB_PORTS-1:0]         r_port;

  // Masking the requests during reset/flush yields no grants, so the pointer holds for free.
  assign w_req_valid = (rst_i || flush_i) ? '0 : req_valid_i;

  rr_multi_pick #(
    .NR_REQ      (NR_REQ),
    .NR_WB_PORTS (NR_WB_PORTS),
    .PTR_W       (PTR_W)
  ) u_rr_multi_pick (
    .i_valid    (w_req_valid),
    .i_ptr      (r_rr_ptr),
    .o_grant    (w_grant),
    .o_ready    (w_ready),
    .o_ptr_next (w_ptr_next)
  );

  assign req_ready_o = w_ready;

  always_comb begin
    w_port_d = '0;
    for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
      for (int unsigned k = 0; k < NR_REQ; k++) begin
        if (w_grant[p][k]) begin
          w_port_d[p].valid    = 1'b1;
          w_port_d[p].trans_id = req_trans_id_i[k];
          w_port_d[p].data     = req_data_i[k];
          w_port_d[p].ex       = req_ex_i[k];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
      r_port   <= '0;
    end else begin
      r_rr_ptr <= w_ptr_next;
      r_port   <= w_port_d;
    end
  end

  for (genvar p = 0; p < NR_WB_PORTS; p++) begin : g_out
    assign wt_valid_o[p] = r_port[p].valid;
    assign trans_id_o[p] = r_port[p].trans_id;
    assign wbdata_o[p]   = r_port[p].data;
    assign ex_o[p]       = r_port[p].ex;
  end

endmodule
